// File: rtl/configure.sv
// Shared configuration for the add arbiter slice: default sizes, the
// arbitration-policy selection, the output-stage state encoding and the
// request bundle that is steered into the shared adder.
// Optional feature macro: ADD_ARB_ROUND_ROBIN_EN (round-robin instead of
// fixed lowest-index-first priority).
package configure;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREQ_DEFAULT = 4;
  localparam int IDW_DEFAULT  = $clog2(NREQ_DEFAULT);

`ifdef ADD_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN_EN = 1'b1;
`else
  localparam bit ROUND_ROBIN_EN = 1'b0;
`endif

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // One requester's operation after the grant mux.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] data0;
    logic [XLEN_DEFAULT-1:0] data1;
    logic                    op;
    logic [IDW_DEFAULT-1:0]  id;
  } add_arb_req_t;

endpackage

// File: rtl/add_arbiter_if.sv
// Request and result handshake bundle between the multiplier-tree control
// (master side) and the add arbiter (slave side).
interface add_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_data0;
  logic [NREQ*XLEN-1:0] req_data1;
  logic [NREQ-1:0]      req_op;
  logic                 res_valid;
  logic                 res_ready;
  logic [XLEN-1:0]      res_data;
  logic [IDW-1:0]       res_id;

  modport master (
    output req_valid, req_data0, req_data1, req_op, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_op, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/add.sv
// Shared add/subtract unit. Subtraction is done as a + ~b + 1 so both
// operations share one carry chain; the result wraps modulo 2^XLEN.
module add #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            op,
  output logic [XLEN-1:0] result
);

  assign result = a + (b ^ {XLEN{op}}) + XLEN'(op);

endmodule

// File: rtl/add_arb_grant.sv
// One-hot grant selection for the add arbiter. With ADD_ARB_ROUND_ROBIN_EN
// the search starts at a pointer that moves past each accepted requester;
// without it the search always starts at index 0 (lowest index wins) and no
// pointer register exists.
module add_arb_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
`ifdef ADD_ARB_ROUND_ROBIN_EN
  input  logic            clock,
  input  logic            reset,
  input  logic            accept,
`endif
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] start;

`ifdef ADD_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;

  assign start = ptr;

  // Pointer moves to the slot after the accepted requester; holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end
`else
  assign start = '0;
`endif

  // First valid requester found scanning upward from start, wrapping.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a variable unassigned, which would infer a latch.
    grant    = '0;
    grant_id = '0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (int'(start) + off) % NREQ;
      if (grant == '0 && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates NREQ requesters onto one shared add/subtract unit and registers
// the winner's result and index in a single output stage with backpressure.
// A full output stage that is being drained can accept a new result on the
// same edge, so throughput is one operation per cycle while res_ready is 1.
// Optional feature macro: ADD_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; the default build uses fixed lowest-index priority.
module add_arbiter
  import configure::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  add_arbiter_if.slave  bus,
  output logic [31:0]   op_count
);

  localparam int IDW = $clog2(NREQ);

  out_state_t      state;
  out_state_t      next_state;
  logic            advance;
  logic            load;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  add_arb_req_t    sel;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] res_data_q;
  logic [IDW-1:0]  res_id_q;

`ifdef ADD_ARB_ROUND_ROBIN_EN
  add_arb_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
    .clock     (clock),
    .reset     (reset),
    .accept    (load),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_id  (grant_id)
  );
`else
  add_arb_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_id  (grant_id)
  );
`endif

  // Steer the granted requester's operands and opcode toward the adder.
  always_comb begin
    sel    = '0;
    sel.id = grant_id;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.data0 = bus.req_data0[i*XLEN +: XLEN];
        sel.data1 = bus.req_data1[i*XLEN +: XLEN];
        sel.op    = bus.req_op[i];
      end
    end
  end

  add #(.XLEN(XLEN)) u_add (
    .a      (sel.data0),
    .b      (sel.data1),
    .op     (sel.op),
    .result (sum)
  );

  // Output-stage state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake: accept when the stage is empty or draining.
  always_comb begin
    advance       = (state == EMPTY) || bus.res_ready;
    load          = advance && (grant != '0);
    bus.req_ready = advance ? grant : '0;
    next_state    = state;
    case (state)
      EMPTY: if (load) next_state = FULL;
      FULL: begin
        if (load) begin
          next_state = FULL;
        end else if (bus.res_ready) begin
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Result register loads the adder output and winner index on acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the datapath register is reset too, so a discarded result
      // never lingers on res_data after an asynchronous reset.
      res_data_q <= '0;
      res_id_q   <= '0;
    end else if (load) begin
      res_data_q <= sum;
      res_id_q   <= sel.id;
    end
  end

  // Completed transfers; wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_count <= '0;
    end else if (state == FULL && bus.res_ready) begin
      op_count <= op_count + 32'd1;
    end
  end

  assign bus.res_valid = (state == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (NREQ=4, XLEN=32). Expected
// values are hand-computed; policy-dependent expectations follow
// ADD_ARB_ROUND_ROBIN_EN.
module tb_add_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] op_count;
  int          n_checks = 0;
  int          n_fails  = 0;

  add_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  add_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
    bus.req_data0[i*XLEN +: XLEN] = a;
    bus.req_data1[i*XLEN +: XLEN] = b;
    bus.req_op[i]                 = op;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.req_op    = '0;
    bus.res_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", bus.res_data, 32'd0);
    check("rst_id", 32'(bus.res_id), 32'd0);
    check("rst_count", op_count, 32'd0);
    reset = 1'b1;
    tick();
    check("idle_valid", 32'(bus.res_valid), 32'd0);
    check("idle_ready", 32'(bus.req_ready), 32'd0);

    // Single requester 2: 5 + 7, then 5 - 7 back-to-back.
    set_req(2, 32'd5, 32'd7, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check("add_valid", 32'(bus.res_valid), 32'd1);
    check("add_data", bus.res_data, 32'd12);
    check("add_id", 32'(bus.res_id), 32'd2);
    check("add_count", op_count, 32'd0);
    set_req(2, 32'd5, 32'd7, 1'b1);
    #1;
    check("drain_accept_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check("sub_data", bus.res_data, 32'hFFFF_FFFE);
    check("sub_id", 32'(bus.res_id), 32'd2);
    check("sub_count", op_count, 32'd1);
`ifdef ADD_ARB_ROUND_ROBIN_EN
    check("ptr_after_2", 32'(u_dut.u_grant.ptr), 32'd3);
`endif
    bus.req_valid = '0;
    tick();
    check("drain_valid", 32'(bus.res_valid), 32'd0);
    check("drain_count", op_count, 32'd2);

    // Wrap-around of the result and of op_count.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    bus.req_valid = 4'b0001;
    tick();
    check("wrap_data", bus.res_data, 32'd0);
    check("wrap_id", 32'(bus.res_id), 32'd0);
    check("wrap_valid", 32'(bus.res_valid), 32'd1);
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    tick();
    check("wrap_hold_valid", 32'(bus.res_valid), 32'd1);
    check("wrap_hold_count", op_count, 32'd2);
    force u_dut.op_count = 32'hFFFF_FFFF;
    #1;
    release u_dut.op_count;
    bus.res_ready = 1'b1;
    tick();
    check("count_wrap", op_count, 32'd0);
    check("count_wrap_valid", 32'(bus.res_valid), 32'd0);

    // Backpressure: result held for 3 cycles, then drain and reload together.
    bus.res_ready = 1'b0;
    set_req(1, 32'd10, 32'd3, 1'b0);
    set_req(3, 32'd100, 32'd1, 1'b1);
    bus.req_valid = 4'b1010;
    #1;
    check("bp_first_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("bp_load_data", bus.res_data, 32'd13);
    check("bp_load_id", 32'(bus.res_id), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      tick();
      check("bp_stall_data", bus.res_data, 32'd13);
      check("bp_stall_id", 32'(bus.res_id), 32'd1);
      check("bp_stall_valid", 32'(bus.res_valid), 32'd1);
      check("bp_stall_count", op_count, 32'd0);
`ifdef ADD_ARB_ROUND_ROBIN_EN
      check("bp_stall_ptr", 32'(u_dut.u_grant.ptr), 32'd2);
`endif
    end
    bus.res_ready = 1'b1;
    #1;
`ifdef ADD_ARB_ROUND_ROBIN_EN
    check("bp_release_ready", 32'(bus.req_ready), 32'h8);
`else
    check("bp_release_ready", 32'(bus.req_ready), 32'h2);
`endif
    tick();
    check("bp_release_count", op_count, 32'd1);
    check("bp_release_valid", 32'(bus.res_valid), 32'd1);
`ifdef ADD_ARB_ROUND_ROBIN_EN
    check("bp_release_data", bus.res_data, 32'd99);
    check("bp_release_id", 32'(bus.res_id), 32'd3);
`else
    check("bp_release_data", bus.res_data, 32'd13);
    check("bp_release_id", 32'(bus.res_id), 32'd1);
`endif
    bus.req_valid = '0;
    tick();
    check("bp_final_valid", 32'(bus.res_valid), 32'd0);
    check("bp_final_count", op_count, 32'd2);

`ifdef ADD_ARB_ROUND_ROBIN_EN
    // Round-robin: all four valid, results cycle 0,1,2,3,... one per cycle.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 10), 32'(i), 1'b0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_id", 32'(bus.res_id), 32'(k % 4));
      check("rr_data", bus.res_data, 32'(11 * (k % 4)));
      check("rr_valid", 32'(bus.res_valid), 32'd1);
      check("rr_count", op_count, 32'(2 + k));
    end
`else
    // Fixed priority: requesters 1 and 3 valid, 1 always wins.
    set_req(1, 32'd20, 32'd2, 1'b0);
    set_req(3, 32'd30, 32'd3, 1'b0);
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fp_ready", 32'(bus.req_ready), 32'h2);
      tick();
      check("fp_id", 32'(bus.res_id), 32'd1);
      check("fp_data", bus.res_data, 32'd22);
      check("fp_count", op_count, 32'(2 + k));
    end
`endif

    // Asynchronous reset mid-stream with a result held.
    check("pre_reset_valid", 32'(bus.res_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_data", bus.res_data, 32'd0);
    check("mid_rst_id", 32'(bus.res_id), 32'd0);
    check("mid_rst_count", op_count, 32'd0);
    bus.req_valid = '0;
    #3;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(bus.res_valid), 32'd0);
    check("post_rst_count", op_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
